jtag_shift_driver: RTL and testbench

- Bench-side JTAG master that drives the tms/tck/tdi pins of orpsoc_top and samples tdo.
- Sits directly upstream of the DUT's debug TAP. Lets directed tests and the ELF-boot flow access the debug unit from a simple command/response interface.
- Converts each accepted command into a TMS/TDI bit sequence at a divided TCK rate, then returns the captured TDO bits.

---
 rtl/jtag_driver_pkg.sv | 38 +++
 rtl/jtag_tck_gen.sv | 36 +++
 rtl/jtag_shift_driver.sv | 178 +++++++++++++++++
 tb/tb_jtag_shift_driver.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/jtag_driver_pkg.sv
// Shared constants for the bench-side JTAG master: command codes, FSM states
// and the leading TMS patterns (LSB is the first TCK) for each command kind.
package jtag_driver_pkg;

    localparam logic [1:0] CMD_TAP_RESET = 2'd0;
    localparam logic [1:0] CMD_SHIFT_IR  = 2'd1;
    localparam logic [1:0] CMD_SHIFT_DR  = 2'd2;
    localparam logic [1:0] CMD_RUN_IDLE  = 2'd3;

    typedef enum logic [2:0] {
        ST_AUTO_RST,
        ST_IDLE,
        ST_PRE,
        ST_SHIFT,
        ST_EXIT,
        ST_WAIT,
        ST_DONE
    } state_t;

    localparam int PRE_W = 6;

    localparam logic [PRE_W-1:0] PRE_PAT_RESET = 6'b011111;
    localparam logic [2:0]       PRE_LEN_RESET = 3'd6;
    localparam logic [PRE_W-1:0] PRE_PAT_IR    = 6'b000011;
    localparam logic [2:0]       PRE_LEN_IR    = 3'd4;
    localparam logic [PRE_W-1:0] PRE_PAT_DR    = 6'b000001;
    localparam logic [2:0]       PRE_LEN_DR    = 3'd3;

    // Zero-length requests still shift one bit; oversize requests saturate.
    function automatic logic [6:0] clamp_len(input logic [6:0] len, input logic [6:0] max_len);
        if (len == '0)
            return 7'd1;
        else if (len > max_len)
            return max_len;
        return len;
    endfunction

endpackage

// File: rtl/jtag_tck_gen.sv
// TCK divider: tck toggles every TCK_DIV enabled clocks; strobes flag the clock
// in which tck rises or falls so the caller can act on that very edge.
module jtag_tck_gen #(
    parameter int TCK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic tck,
    output logic rise_stb,
    output logic fall_stb
);

    localparam int             CW   = $clog2(TCK_DIV);
    localparam logic [CW-1:0]  LAST = CW'(TCK_DIV - 1);

    logic [CW-1:0] cnt;
    logic          term;

    assign term     = en && (cnt == LAST);
    assign rise_stb = term && !tck;
    assign fall_stb = term && tck;

    always_ff @(posedge clk) begin
        if (!rst_n || !en) begin
            cnt <= '0;
            tck <= 1'b0;
        end else if (cnt == LAST) begin
            cnt <= '0;
            tck <= ~tck;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/jtag_shift_driver.sv
// JTAG master: turns command/response transactions into TMS/TDI sequences at a
// divided TCK rate and returns captured TDO bits.
module jtag_shift_driver
    import jtag_driver_pkg::*;
#(
    parameter int TCK_DIV = 4,
    parameter int MAX_LEN = 64
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_n_i,
    input  logic               cmd_valid_i,
    output logic               cmd_ready_o,
    input  logic [1:0]         cmd_type_i,
    input  logic [6:0]         cmd_len_i,
    input  logic [MAX_LEN-1:0] cmd_data_i,
    output logic               rsp_valid_o,
    output logic [MAX_LEN-1:0] rsp_data_o,
    output logic               busy_o,
    output logic               tck_o,
    output logic               tms_o,
    output logic               tdi_o,
    input  logic               tdo_i
);

    localparam int IDXW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    state_t             state;
    logic [PRE_W-1:0]   pre_pat;
    logic [2:0]         pre_cnt;
    logic [IDXW-1:0]    bit_idx;
    logic [IDXW-1:0]    last_idx;
    logic [MAX_LEN-1:0] data_sr;
    logic [MAX_LEN-1:0] cap;
    logic               rsp_pend;
    logic               tck_en;
    logic               rise_stb;
    logic               fall_stb;
    logic [6:0]         len_c;

    assign tck_en = state inside {ST_AUTO_RST, ST_PRE, ST_SHIFT, ST_EXIT, ST_WAIT};
    assign len_c  = clamp_len(cmd_len_i, 7'(MAX_LEN));

    jtag_tck_gen #(
        .TCK_DIV(TCK_DIV)
    ) u_tck_gen (
        .clk      (wb_clk_i),
        .rst_n    (wb_rst_n_i),
        .en       (tck_en),
        .tck      (tck_o),
        .rise_stb (rise_stb),
        .fall_stb (fall_stb)
    );

    // TMS/TDI for the next TCK are loaded on the falling edge of the current one;
    // the first TCK of a command is primed at the handshake.
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n_i) begin
            state       <= ST_AUTO_RST;
            pre_pat     <= PRE_PAT_RESET;
            pre_cnt     <= PRE_LEN_RESET;
            bit_idx     <= '0;
            last_idx    <= '0;
            data_sr     <= '0;
            cap         <= '0;
            rsp_pend    <= 1'b0;
            tms_o       <= 1'b1;
            tdi_o       <= 1'b0;
            cmd_ready_o <= 1'b0;
            rsp_valid_o <= 1'b0;
            rsp_data_o  <= '0;
            busy_o      <= 1'b1;
        end else begin
            rsp_valid_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cmd_valid_i && cmd_ready_o) begin
                        cmd_ready_o <= 1'b0;
                        busy_o      <= 1'b1;
                        bit_idx     <= '0;
                        last_idx    <= IDXW'(len_c - 7'd1);
                        data_sr     <= cmd_data_i;
                        cap         <= '0;
                        rsp_pend    <= 1'b1;
                        tdi_o       <= 1'b0;
                        case (cmd_type_i)
                            CMD_TAP_RESET: begin
                                state   <= ST_AUTO_RST;
                                pre_pat <= PRE_PAT_RESET;
                                pre_cnt <= PRE_LEN_RESET;
                                tms_o   <= PRE_PAT_RESET[0];
                            end
                            CMD_SHIFT_IR: begin
                                state   <= ST_PRE;
                                pre_pat <= PRE_PAT_IR;
                                pre_cnt <= PRE_LEN_IR;
                                tms_o   <= PRE_PAT_IR[0];
                            end
                            CMD_SHIFT_DR: begin
                                state   <= ST_PRE;
                                pre_pat <= PRE_PAT_DR;
                                pre_cnt <= PRE_LEN_DR;
                                tms_o   <= PRE_PAT_DR[0];
                            end
                            default: begin
                                state <= ST_WAIT;
                                tms_o <= 1'b0;
                            end
                        endcase
                    end
                end
                ST_AUTO_RST, ST_PRE: begin
                    if (fall_stb) begin
                        if (pre_cnt == 3'd1) begin
                            if (state == ST_PRE) begin
                                state <= ST_SHIFT;
                                tms_o <= (last_idx == '0);
                                tdi_o <= data_sr[0];
                            end else begin
                                state <= ST_DONE;
                                tms_o <= 1'b0;
                            end
                        end else begin
                            pre_pat <= pre_pat >> 1;
                            pre_cnt <= pre_cnt - 3'd1;
                            tms_o   <= pre_pat[1];
                        end
                    end
                end
                ST_SHIFT: begin
                    if (rise_stb)
                        cap[bit_idx] <= tdo_i;
                    if (fall_stb) begin
                        if (bit_idx == last_idx) begin
                            state   <= ST_EXIT;
                            pre_cnt <= 3'd2;
                            tms_o   <= 1'b1;
                            tdi_o   <= 1'b0;
                        end else begin
                            bit_idx <= bit_idx + IDXW'(1);
                            data_sr <= data_sr >> 1;
                            tdi_o   <= data_sr[1];
                            tms_o   <= ((bit_idx + IDXW'(1)) == last_idx);
                        end
                    end
                end
                ST_EXIT: begin
                    if (fall_stb) begin
                        tms_o <= 1'b0;
                        if (pre_cnt == 3'd1)
                            state <= ST_DONE;
                        else
                            pre_cnt <= pre_cnt - 3'd1;
                    end
                end
                ST_WAIT: begin
                    if (fall_stb) begin
                        if (bit_idx == last_idx)
                            state <= ST_DONE;
                        else
                            bit_idx <= bit_idx + IDXW'(1);
                    end
                end
                ST_DONE: begin
                    state       <= ST_IDLE;
                    cmd_ready_o <= 1'b1;
                    busy_o      <= 1'b0;
                    tms_o       <= 1'b0;
                    tdi_o       <= 1'b0;
                    rsp_valid_o <= rsp_pend;
                    if (rsp_pend)
                        rsp_data_o <= cap;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_jtag_shift_driver.sv
// Directed bench for jtag_shift_driver: a behavioural TAP (IDCODE/bypass) or a
// one-TCK loopback flop answers on tdo; TCK edges are logged for sequence checks.
module tb_jtag_shift_driver;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic        cmd_valid = 1'b0;
    logic [1:0]  cmd_type  = 2'd0;
    logic [6:0]  cmd_len   = 7'd0;
    logic [63:0] cmd_data  = 64'd0;
    logic        cmd_ready;
    logic        rsp_valid;
    logic [63:0] rsp_data;
    logic        busy;
    logic        tck, tms, tdi, tdo;

    logic lb_mode = 1'b0;
    logic lb_q    = 1'b0;
    logic tap_tdo = 1'b0;

    int checks = 0, errors = 0;
    int tck_cnt = 0, rsp_cnt = 0, cyc = 0, fall_cyc = 0;
    logic tms_at [0:1023];
    logic tdi_at [0:1023];
    int   rise_cyc [0:1023];

    always #5 clk = ~clk;

    jtag_shift_driver #(.TCK_DIV(4), .MAX_LEN(64)) dut (
        .wb_clk_i    (clk),
        .wb_rst_n_i  (rst_n),
        .cmd_valid_i (cmd_valid),
        .cmd_ready_o (cmd_ready),
        .cmd_type_i  (cmd_type),
        .cmd_len_i   (cmd_len),
        .cmd_data_i  (cmd_data),
        .rsp_valid_o (rsp_valid),
        .rsp_data_o  (rsp_data),
        .busy_o      (busy),
        .tck_o       (tck),
        .tms_o       (tms),
        .tdi_o       (tdi),
        .tdo_i       (tdo)
    );

    assign tdo = lb_mode ? lb_q : tap_tdo;

    always @(posedge clk) cyc++;
    always @(posedge clk) if (rsp_valid === 1'b1) rsp_cnt++;
    always @(posedge tck) begin
        tms_at[tck_cnt % 1024]   = tms;
        tdi_at[tck_cnt % 1024]   = tdi;
        rise_cyc[tck_cnt % 1024] = cyc;
        tck_cnt++;
    end
    always @(negedge tck) fall_cyc = cyc;
    always @(posedge tck) lb_q <= tdi;

    // Behavioural TAP controller (IEEE 1149.1 state graph), 4-bit IR.
    typedef enum {TLR, RTI, SDS, CDR, SDR, E1D, PDR, E2D, UDR,
                  SIS, CIR, SIR, E1I, PIR, E2I, UIR} tap_t;
    localparam logic [3:0]  IR_IDCODE = 4'b0010;
    localparam logic [31:0] IDCODE    = 32'h1495_1185;
    tap_t        tap   = TLR;
    logic [3:0]  ir    = IR_IDCODE;
    logic [3:0]  ir_sr = 4'd0;
    logic [31:0] dr_sr = 32'd0;

    always @(posedge tck) begin
        case (tap)
            TLR: ir <= IR_IDCODE;
            CDR: dr_sr <= (ir == IR_IDCODE) ? IDCODE : 32'd0;
            SDR: dr_sr <= (ir == IR_IDCODE) ? {tdi, dr_sr[31:1]} : {31'd0, tdi};
            CIR: ir_sr <= 4'b0001;
            SIR: ir_sr <= {tdi, ir_sr[3:1]};
            UIR: ir <= ir_sr;
            default: ;
        endcase
        case (tap)
            TLR: tap <= tms ? TLR : RTI;
            RTI: tap <= tms ? SDS : RTI;
            SDS: tap <= tms ? SIS : CDR;
            CDR: tap <= tms ? E1D : SDR;
            SDR: tap <= tms ? E1D : SDR;
            E1D: tap <= tms ? UDR : PDR;
            PDR: tap <= tms ? E2D : PDR;
            E2D: tap <= tms ? UDR : SDR;
            UDR: tap <= tms ? SDS : RTI;
            SIS: tap <= tms ? TLR : CIR;
            CIR: tap <= tms ? E1I : SIR;
            SIR: tap <= tms ? E1I : SIR;
            E1I: tap <= tms ? UIR : PIR;
            PIR: tap <= tms ? E2I : PIR;
            E2I: tap <= tms ? UIR : SIR;
            default: tap <= tms ? SDS : RTI;
        endcase
    end

    always @(negedge tck) begin
        if (tap == SDR)      tap_tdo <= dr_sr[0];
        else if (tap == SIR) tap_tdo <= ir_sr[0];
        else                 tap_tdo <= 1'b0;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] tms_seq(input int first, input int n);
        logic [15:0] v = '0;
        for (int i = 0; i < n; i++) v[i] = tms_at[(first + i) % 1024];
        return v;
    endfunction

    function automatic logic [15:0] tdi_seq(input int first, input int n);
        logic [15:0] v = '0;
        for (int i = 0; i < n; i++) v[i] = tdi_at[(first + i) % 1024];
        return v;
    endfunction

    task automatic wait_ready(input string tag);
        int k = 0;
        while (cmd_ready !== 1'b1 && k < 500) begin
            @(negedge clk);
            k++;
        end
        chk(tag, 64'(cmd_ready), 64'd1);
    endtask

    // Issues one command from a negedge and returns its response and TCK count.
    task automatic do_cmd(input string tag, input logic [1:0] t, input logic [6:0] l,
                          input logic [63:0] d, output logic [63:0] r,
                          output int n, output int first);
        int k = 0;
        int r0;
        wait_ready({tag, "_ready"});
        r0 = rsp_cnt;
        cmd_valid = 1'b1;
        cmd_type  = t;
        cmd_len   = l;
        cmd_data  = d;
        first     = tck_cnt;
        @(negedge clk);
        cmd_valid = 1'b0;
        chk({tag, "_ready_drop"}, 64'({cmd_ready, busy}), 64'b01);
        while (rsp_valid !== 1'b1 && k < 2000) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_rsp_seen"}, 64'(rsp_valid), 64'd1);
        chk({tag, "_rsp_gap"}, 64'(cyc - fall_cyc), 64'd1);
        chk({tag, "_ready_with_rsp"}, 64'(cmd_ready), 64'd1);
        r = rsp_data;
        n = tck_cnt - first;
        @(negedge clk);
        chk({tag, "_rsp_pulse"}, 64'({rsp_valid, rsp_data === r}), 64'b01);
        chk({tag, "_rsp_once"}, 64'(rsp_cnt - r0), 64'd1);
    endtask

    logic [63:0] r;
    int n, first, base, rc0, k;

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_pins", 64'({tck, tms, tdi, cmd_ready, rsp_valid, busy}), 64'b010001);
        chk("reset_data", rsp_data, 64'd0);

        rst_n = 1'b1;
        base  = tck_cnt;
        wait_ready("auto_ready");
        chk("auto_tck_cnt", 64'(tck_cnt - base), 64'd6);
        chk("auto_tms", 64'(tms_seq(base, 6)), 64'b011111);
        chk("auto_period", 64'(rise_cyc[(base + 1) % 1024] - rise_cyc[base % 1024]), 64'd8);
        chk("idle_pins", 64'({tck, tms, tdi, busy}), 64'b0000);

        do_cmd("idcode", 2'd2, 7'd32, 64'd0, r, n, first);
        chk("idcode_data", r, 64'h0000_0000_1495_1185);
        chk("idcode_tcks", 64'(n), 64'd37);

        lb_mode = 1'b1;
        do_cmd("lb8", 2'd2, 7'd8, 64'hA5, r, n, first);
        chk("lb8_data", r, 64'h4A);
        chk("lb8_tcks", 64'(n), 64'd13);

        do_cmd("ir4", 2'd1, 7'd4, 64'h8, r, n, first);
        chk("ir4_tcks", 64'(n), 64'd10);
        chk("ir4_tms", 64'(tms_seq(first, 10)), 64'h183);
        chk("ir4_tdi", 64'(tdi_seq(first, 10)), 64'h080);
        chk("ir4_data", r, 64'd0);

        do_cmd("len0", 2'd2, 7'd0, 64'hFFFF_FFFF_FFFF_FFFF, r, n, first);
        chk("len0_tcks", 64'(n), 64'd6);
        chk("len0_tms", 64'(tms_seq(first, 6)), 64'b011001);
        chk("len0_tdi", 64'(tdi_seq(first, 6)), 64'b001000);
        chk("len0_data", r, 64'd0);

        do_cmd("len100", 2'd2, 7'd100, 64'hFFFF_FFFF_FFFF_FFFF, r, n, first);
        chk("len100_tcks", 64'(n), 64'd69);
        chk("len100_last_tms", 64'({tms_at[(first + 66) % 1024], tms_at[(first + 65) % 1024]}), 64'b10);
        chk("len100_data", r, 64'hFFFF_FFFF_FFFF_FFFE);

        do_cmd("run5", 2'd3, 7'd5, 64'hFFFF, r, n, first);
        chk("run5_tcks", 64'(n), 64'd5);
        chk("run5_tms_tdi", 64'({tms_seq(first, 5), tdi_seq(first, 5)}), 64'd0);
        chk("run5_data", r, 64'd0);

        do_cmd("lb8b", 2'd2, 7'd8, 64'hA5, r, n, first);
        chk("lb8b_data", r, 64'h4A);

        lb_mode = 1'b0;
        do_cmd("tapreset", 2'd0, 7'd9, 64'hFF, r, n, first);
        chk("tapreset_tcks", 64'(n), 64'd6);
        chk("tapreset_tms", 64'(tms_seq(first, 6)), 64'b011111);
        chk("tapreset_data", r, 64'd0);

        // Abort a DR scan with a one-clock reset once shift bit 10 has risen.
        wait_ready("abort_ready");
        rc0       = rsp_cnt;
        cmd_valid = 1'b1;
        cmd_type  = 2'd2;
        cmd_len   = 7'd32;
        cmd_data  = 64'd0;
        first     = tck_cnt;
        @(negedge clk);
        cmd_valid = 1'b0;
        k = 0;
        while (tck_cnt - first < 14 && k < 500) begin
            @(negedge clk);
            k++;
        end
        chk("abort_reach_bit10", 64'(tck_cnt - first), 64'd14);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("abort_pins", 64'({tck, tms, cmd_ready, busy}), 64'b0101);
        base = tck_cnt;
        wait_ready("abort_auto_ready");
        chk("abort_auto_tcks", 64'(tck_cnt - base), 64'd6);
        chk("abort_auto_tms", 64'(tms_seq(base, 6)), 64'b011111);
        chk("abort_no_rsp", 64'(rsp_cnt - rc0), 64'd0);

        do_cmd("idcode2", 2'd2, 7'd32, 64'd0, r, n, first);
        chk("idcode2_data", r, 64'h0000_0000_1495_1185);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
